// File: rtl/uart_tx_fifo.sv
// Buffered front end for uart_tx: FIFO plus a one-request-per-frame drain FSM.
// Optional status outputs (fifo_level, overflow) with UART_TX_FIFO_STATUS_EN.
module uart_tx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH        = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [PAYLOAD_BITS-1:0] wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [PAYLOAD_BITS-1:0] tx_data,
  output logic                    tx_en,
  input  logic                    tx_busy,
  output logic                    fifo_empty,
  output logic                    fifo_full
`ifdef UART_TX_FIFO_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    overflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW:0]             count;
  logic [1:0]              state;
  logic                    push;
  logic                    pop;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign wr_ready   = !fifo_full;
  assign push       = wr_valid && wr_ready;
  assign pop        = (state == IDLE) && !fifo_empty && !tx_busy;
  assign tx_en      = (state == ISSUE);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + (AW+1)'(1);
      else if (pop && !push)
        count <= count - (AW+1)'(1);
    end
  end

  // tx_data is only loaded on a pop, so it holds across the whole frame
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      tx_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            state   <= ISSUE;
            tx_data <= mem[rd_ptr];
          end
        end
        ISSUE: state <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (tx_busy)
            state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_FIFO_STATUS_EN
  assign fifo_level = count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      overflow <= 1'b0;
    else if (wr_valid && fifo_full)
      overflow <= 1'b1;
  end
`endif

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter PAYLOAD_BITS, default 8, data word width; SHALL match the downstream uart_tx PAYLOAD_BITS.
REQ-002 Parameter DEPTH, default 16, FIFO capacity in words; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  top level system clock; all state SHALL change on its rising edge.
REQ-004 resetn  input  1  reset; SHALL be asynchronous and active-low.
REQ-005 wr_data  input  PAYLOAD_BITS  word offered by the upstream producer.
REQ-006 wr_valid  input  1  wr_data is valid this cycle.
REQ-007 wr_ready  output  1  FIFO accepts a word this cycle.
REQ-008 tx_data  output  PAYLOAD_BITS  word presented to uart_tx_data.
REQ-009 tx_en  output  1  one-cycle send request to uart_tx_en.
REQ-010 tx_busy  input  1  uart_tx_busy from the transmitter.
REQ-011 fifo_empty  output  1  FIFO holds zero words.
REQ-012 fifo_full  output  1  FIFO holds DEPTH words.

Function
REQ-013 Write handshake SHALL occur on a rising edge where wr_valid and wr_ready are both 1; that word SHALL be stored at the tail.
REQ-014 wr_ready SHALL equal !fifo_full, including in cycles where a pop occurs, so there is no full-FIFO write bypass.
REQ-015 Occupancy SHALL be a DEPTH+1-state count, with fifo_empty = (count==0) and fifo_full = (count==DEPTH); read and write pointers SHALL wrap modulo DEPTH.
REQ-016 A simultaneous push and pop SHALL leave the count unchanged and preserve FIFO order.
REQ-017 The drain FSM SHALL have the states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-018 IDLE->ISSUE SHALL occur when !fifo_empty and !tx_busy; on that edge the head word SHALL be popped into the tx_data register.
REQ-019 In ISSUE, tx_en SHALL be 1 for exactly one cycle; the FSM SHALL then move unconditionally to WAIT_BUSY.
REQ-020 WAIT_BUSY->WAIT_DONE SHALL occur when tx_busy==1; the FSM SHALL wait indefinitely otherwise.
REQ-021 WAIT_DONE->IDLE SHALL occur when tx_busy==0.
REQ-022 tx_en SHALL be 0 in every state except ISSUE, so that at most one request is issued per transmitted frame.
REQ-023 tx_data SHALL stay stable from the pop edge until the next pop.
REQ-024 Latency SHALL be as follows: with the FIFO empty, the FSM in IDLE and tx_busy low, a word handshaken in cycle C SHALL appear on tx_data with tx_en=1 in cycle C+2.
REQ-025 Words SHALL be transmitted in write order, with no loss and no duplication.

Reset
REQ-026 When resetn is low: FIFO SHALL be emptied with contents discarded, pointers=0, FSM=IDLE, tx_en=0, tx_data=0, fifo_empty=1, fifo_full=0, wr_ready=1.
REQ-027 Reset asserted mid-frame SHALL take effect immediately and SHALL produce no further tx_en until new words are written after release.

Configuration
REQ-028 Macro UART_TX_FIFO_STATUS_EN, when defined, SHALL add output fifo_level (clog2(DEPTH)+1 bits), equal to the current count.
REQ-029 Macro UART_TX_FIFO_STATUS_EN, when defined, SHALL also add output overflow (1 bit), a sticky flag set when wr_valid==1 while fifo_full==1 and cleared only by reset (reset value 0).
REQ-030 When UART_TX_FIFO_STATUS_EN is undefined, the fifo_level and overflow ports and their logic SHALL be absent, with all other behaviour identical.

Verification
REQ-031 Write 0xA5 to an empty FIFO with tx_busy=0 -> tx_data=0xA5 and tx_en=1 exactly two cycles after the handshake, for exactly one cycle.
REQ-032 Burst 16 words 0x00..0x0F (DEPTH=16) while the uart_tx model is busy -> fifo_full=1, wr_ready=0, and the 17th word is not accepted (overflow=1 when the macro is defined).
REQ-033 Connect a real uart_tx (CLK_HZ=50 MHz, BIT_RATE=9600) and write 3 words 0x55, 0x0F, 0xF0 -> three serial frames decoded in order, with one tx_en per frame.
REQ-034 Push and pop on the same edge at count=1 -> count stays 1, order preserved, fifo_empty never asserted.
REQ-035 Assert resetn low during WAIT_DONE with 5 words queued -> tx_en=0, fifo_empty=1, fifo_level=0, and no tx_en after release until a new write.
REQ-036 Write 40 words with random wr_valid gaps -> pointers wrap twice and all 40 words are transmitted in order.
